// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin arbiter feeding a single UART transmit handshake
module uart_tx_arbiter #(
    parameter int NumReq      = 2,
    parameter int IdleTimeout = 1024
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [8*NumReq-1:0]   ReqData,
    input  logic [NumReq-1:0]     ReqValid,
    input  logic [NumReq-1:0]     ReqLast,
    output logic [NumReq-1:0]     ReqReady,
    output logic [7:0]            DataIn,
    output logic                  DataInValid,
    input  logic                  DataInReady,
    output logic [NumReq-1:0]     Grant,
    output logic                  Busy
);

    // Index width covers 2..4 requesters.
    localparam int IdxW = (NumReq > 2) ? 2 : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;

    logic              locked;
    logic              win_found;
    logic [IdxW-1:0]   win_idx;
    logic              own_valid;
    logic              own_last;
    logic [7:0]        own_data;
    logic              out_free;
    logic              accept;
    logic              timeout_hit;
    logic              release_lock;

    assign locked = (state_q == ST_LOCKED);

    // Owner's request lines, selected by the registered owner index.
    always_comb begin
        own_valid = ReqValid[owner_q];
        own_last  = ReqLast[owner_q];
        own_data  = ReqData[{owner_q, 3'b000} +: 8];
    end

    // Handshake, timeout and release conditions; the output slot is free when empty or draining now.
    always_comb begin
        out_free     = !valid_q || DataInReady;
        accept       = locked && own_valid && out_free;
        timeout_hit  = (IdleTimeout != 0) && locked && !own_valid
                       && (cnt_q == 16'(IdleTimeout - 1));
        release_lock = (accept && own_last) || timeout_hit;
    end

    // Round-robin search starting just after the most recently served index.
    always_comb begin : p_round_robin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NumReq; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!win_found && ReqValid[cand]) begin
                win_found = 1'b1;
                win_idx   = IdxW'(cand);
            end
        end
    end

    // FSM state register together with owner, round-robin pointer and idle counter.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= IdxW'(NumReq - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: lock the arbitration winner, release on last byte or idle timeout.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (win_found) begin
                    state_d = ST_LOCKED;
                    owner_d = win_idx;
                end
            end
            ST_LOCKED: begin
                if (release_lock) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (own_valid || (IdleTimeout == 0)) begin
                    cnt_d = '0;
                end else if (cnt_q != 16'hffff) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: only the owner sees ready, and only while the output slot can take a byte.
    always_comb begin
        ReqReady = '0;
        Grant    = '0;
        if (locked) begin
            Grant[owner_q]    = 1'b1;
            ReqReady[owner_q] = own_valid && out_free;
        end
        Busy = locked || valid_q;
    end

    // One-entry output register: load on accept, otherwise empty after the UART takes the byte.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (accept) begin
            data_d  = own_data;
            valid_d = 1'b1;
        end else if (DataInReady) begin
            valid_d = 1'b0;
        end
    end

    // Output register storage; a reset discards any byte still waiting for the UART.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign DataIn      = data_q;
    assign DataInValid = valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with two requesters
module tb_uart_tx_arbiter;

    logic        Clock;
    logic        Reset;
    logic [15:0] ReqData;
    logic [1:0]  ReqValid;
    logic [1:0]  ReqLast;
    logic [1:0]  ReqReady;
    logic [7:0]  DataIn;
    logic        DataInValid;
    logic        DataInReady;
    logic [1:0]  Grant;
    logic        Busy;

    logic [7:0]  rd [2];
    logic        rv [2];
    logic        rl [2];

    assign ReqData  = {rd[1], rd[0]};
    assign ReqValid = {rv[1], rv[0]};
    assign ReqLast  = {rl[1], rl[0]};

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_b;
    logic        mon_en;

    uart_tx_arbiter #(
        .NumReq      (2),
        .IdleTimeout (8)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ReqData     (ReqData),
        .ReqValid    (ReqValid),
        .ReqLast     (ReqLast),
        .ReqReady    (ReqReady),
        .DataIn      (DataIn),
        .DataInValid (DataInValid),
        .DataInReady (DataInReady),
        .Grant       (Grant),
        .Busy        (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mbase(input int r, input int k);
        return 8'(32 + r * 64 + k * 4);
    endfunction

    // Scoreboard: every UART handshake must deliver the next predicted byte.
    always @(negedge Clock) begin
        if (mon_en && !Reset && DataInValid && DataInReady) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_byte", {24'd0, DataIn}, 32'hffff_ffff);
            end else begin
                exp_b = exp_q.pop_front();
                check("sb_byte", {24'd0, DataIn}, {24'd0, exp_b});
            end
        end
    end

    task automatic send_msg(input int r, input int n, input logic [7:0] base);
        int  waited;
        logic accepted;
        for (int b = 0; b < n; b++) begin
            rd[r] = base + 8'(b);
            rl[r] = (b == n - 1);
            rv[r] = 1'b1;
            waited   = 0;
            accepted = 1'b0;
            while (!accepted && waited < 200) begin
                @(negedge Clock);
                if (ReqReady[r]) accepted = 1'b1;
                waited++;
            end
            if (!accepted) check("send_accept_timeout", 0, 1);
            @(posedge Clock); #1;
        end
        rv[r] = 1'b0;
        rl[r] = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge Clock);
            w++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) @(posedge Clock);
        #1;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(posedge Clock); #1;
    endtask

    initial begin : main
        int last_m;
        int sent [2];
        int r;
        int n;

        Reset = 1'b1;
        DataInReady = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 8'h00;
            rv[i] = 1'b0;
            rl[i] = 1'b0;
        end
        #1;
        check("rst_grant", Grant, 0);
        check("rst_valid", DataInValid, 0);
        check("rst_data", DataIn, 0);
        check("rst_busy", Busy, 0);
        check("rst_ready", ReqReady, 0);
        @(posedge Clock); #1;
        Reset = 1'b0;

        // Req0 alone, three bytes, cycle-exact latency
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        @(posedge Clock); #1;
        rd[0] = 8'h41; rl[0] = 1'b0; rv[0] = 1'b1;
        #1;
        check("t1_c0_ready", ReqReady, 0);
        check("t1_c0_grant", Grant, 0);
        @(posedge Clock); #1;
        check("t1_c1_grant", Grant, 2'b01);
        check("t1_c1_ready", ReqReady, 2'b01);
        check("t1_c1_valid", DataInValid, 0);
        @(posedge Clock); #1;
        check("t1_c2_valid", DataInValid, 1);
        check("t1_c2_data", DataIn, 8'h41);
        rd[0] = 8'h42;
        @(posedge Clock); #1;
        check("t1_c3_data", DataIn, 8'h42);
        rd[0] = 8'h43; rl[0] = 1'b1;
        @(posedge Clock); #1;
        check("t1_c4_data", DataIn, 8'h43);
        check("t1_c4_grant", Grant, 0);
        check("t1_c4_busy", Busy, 1);
        rv[0] = 1'b0; rl[0] = 1'b0;
        @(posedge Clock); #1;
        check("t1_c5_valid", DataInValid, 0);
        check("t1_c5_busy", Busy, 0);
        drain();

        // Round robin over six two-byte messages, both requesters contending
        pulse_reset();
        last_m = 1;
        sent[0] = 0; sent[1] = 0;
        for (int m = 0; m < 6; m++) begin
            r = (last_m + 1) % 2;
            if (sent[r] == 3) r = 1 - r;
            exp_q.push_back(mbase(r, sent[r]));
            exp_q.push_back(mbase(r, sent[r]) + 8'd1);
            sent[r]++;
            last_m = r;
        end
        fork
            for (int k = 0; k < 3; k++) send_msg(0, 2, mbase(0, k));
            for (int k = 0; k < 3; k++) send_msg(1, 2, mbase(1, k));
        join
        drain();

        // Req1 arrives mid-message and must wait for Req0's last byte
        for (int b = 0; b < 4; b++) exp_q.push_back(8'h50 + 8'(b));
        exp_q.push_back(8'h60); exp_q.push_back(8'h61);
        fork
            send_msg(0, 4, 8'h50);
            begin
                repeat (2) @(posedge Clock);
                #1;
                send_msg(1, 2, 8'h60);
            end
            begin
                repeat (10) begin
                    @(negedge Clock);
                    if (Grant == 2'b01 && ReqValid[1]) check("t3_req1_blocked", ReqReady[1], 0);
                end
            end
        join
        drain();

        // UART stalls for 20 cycles with a byte pending
        for (int b = 0; b < 4; b++) exp_q.push_back(8'h70 + 8'(b));
        fork
            send_msg(0, 4, 8'h70);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(posedge Clock); #1;
                    if (DataInValid) break;
                end
                check("t4_first_valid", DataInValid, 1);
                DataInReady = 1'b0;
                repeat (20) begin
                    @(negedge Clock);
                    check("t4_hold_data", DataIn, 8'h70);
                    check("t4_hold_ready", ReqReady, 0);
                end
                @(posedge Clock); #1;
                DataInReady = 1'b1;
            end
        join
        drain();

        // Idle timeout releases Req0's lock, Req1 then sends a single-byte message
        exp_q.push_back(8'h77); exp_q.push_back(8'h88);
        rd[0] = 8'h77; rl[0] = 1'b0; rv[0] = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge Clock);
            if (ReqReady[0]) break;
            n++;
        end
        check("t5_req0_accept", ReqReady[0], 1);
        @(posedge Clock); #1;
        rv[0] = 1'b0;
        rd[1] = 8'h88; rl[1] = 1'b1; rv[1] = 1'b1;
        n = 0;
        while (Grant != 2'b10 && n < 40) begin
            @(posedge Clock); #1;
            n++;
        end
        check("t5_timeout_cycles", n, 9);
        check("t5_ready1", ReqReady, 2'b10);
        @(posedge Clock); #1;
        rv[1] = 1'b0; rl[1] = 1'b0;
        check("t5_single_byte_lock", Grant, 0);
        drain();

        // Reset in the middle of a locked message with a byte pending
        DataInReady = 1'b0;
        rd[0] = 8'h99; rl[0] = 1'b0; rv[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock); #1;
            if (DataInValid) break;
        end
        check("t6_pending", DataInValid, 1);
        check("t6_busy", Busy, 1);
        Reset = 1'b1;
        #1;
        check("t6_rst_grant", Grant, 0);
        check("t6_rst_valid", DataInValid, 0);
        check("t6_rst_data", DataIn, 0);
        check("t6_rst_busy", Busy, 0);
        check("t6_rst_ready", ReqReady, 0);
        rv[0] = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        DataInReady = 1'b1;
        exp_q.push_back(8'hA0); exp_q.push_back(8'hB0);
        fork
            send_msg(0, 1, 8'hA0);
            send_msg(1, 1, 8'hB0);
            begin
                @(posedge Clock); #1;
                check("t6_first_grant", Grant, 2'b01);
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
